// File: rtl/multi_timer_pkg.sv
// Shared register map and control-field positions for the multi-channel timer.
package multi_timer_pkg;

    // Register offsets within a channel (address[1:0])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL register bit positions
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE    = 1;
    localparam int unsigned CTRL_IRQEN   = 2;
    localparam int unsigned CTRL_PRE_LSB = 8;

    // CTRL.MODE encodings
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: control/load registers, prescaler, up-counter and sticky expiry flag.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 24,
    parameter int unsigned PRE_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_ctrl_i,
    input  logic        wr_load_i,
    input  logic        wr_count_i,
    input  logic        wr_status_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ctrl_o,
    output logic [31:0] load_o,
    output logic [31:0] count_o,
    output logic        flag_o,
    output logic        irq_req_o
);

    logic             en_q, en_d;
    logic             mode_q, mode_d;
    logic             irq_en_q, irq_en_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    logic             tick;
    logic             expire;
    logic             unused_wdata;

    // Only a slice of the write bus is meaningful to any one register
    assign unused_wdata = ^wdata_i;

    assign tick   = en_q && (pcnt_q == pre_q);
    assign expire = tick && (count_q == load_q);

    // Next-state: counting first, then bus writes layered on top so writes win
    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        irq_en_d = irq_en_q;
        pre_d    = pre_q;
        pcnt_d   = pcnt_q;
        load_d   = load_q;
        count_d  = count_q;
        flag_d   = flag_q;

        if (en_q) begin
            pcnt_d = tick ? '0 : pcnt_q + PRE_W'(1);
        end

        if (tick) begin
            if (!expire) begin
                count_d = count_q + CNT_W'(1);
            end else if (mode_q == MODE_PERIODIC) begin
                count_d = '0;
            end else begin
                // One-shot: count parks at LOAD and the channel disarms
                en_d = 1'b0;
            end
        end

        // Expiry set has priority over a same-cycle W1C
        if (wr_status_i && wdata_i[0]) begin
            flag_d = 1'b0;
        end
        if (expire) begin
            flag_d = 1'b1;
        end

        if (wr_ctrl_i) begin
            en_d     = wdata_i[CTRL_EN];
            mode_d   = wdata_i[CTRL_MODE];
            irq_en_d = wdata_i[CTRL_IRQEN];
            pre_d    = wdata_i[CTRL_PRE_LSB +: PRE_W];
            // Rising EN restarts from zero; rewriting EN=1 leaves counting alone
            if (!en_q && wdata_i[CTRL_EN]) begin
                count_d = '0;
                pcnt_d  = '0;
            end
        end

        if (wr_load_i) begin
            load_d = wdata_i[CNT_W-1:0];
        end

        if (wr_count_i) begin
            count_d = '0;
            pcnt_d  = '0;
        end
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q     <= 1'b0;
            mode_q   <= MODE_ONESHOT;
            irq_en_q <= 1'b0;
            pre_q    <= '0;
            pcnt_q   <= '0;
            load_q   <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            irq_en_q <= irq_en_d;
            pre_q    <= pre_d;
            pcnt_q   <= pcnt_d;
            load_q   <= load_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Register readback views, zero-extended to the bus width
    always_comb begin
        ctrl_o                           = '0;
        ctrl_o[CTRL_EN]                  = en_q;
        ctrl_o[CTRL_MODE]                = mode_q;
        ctrl_o[CTRL_IRQEN]               = irq_en_q;
        ctrl_o[CTRL_PRE_LSB +: PRE_W]    = pre_q;
    end

    assign load_o    = 32'(load_q);
    assign count_o   = 32'(count_q);
    assign flag_o    = flag_q;
    assign irq_req_o = flag_q & irq_en_q;

endmodule

// File: rtl/multi_channel_timer.sv
// Avalon-MM multi-channel timer: address decode, registered read mux and interrupt OR.
module multi_channel_timer
    import multi_timer_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned PRE_W  = 8
) (
    input  logic                        csi_clk,
    input  logic                        rsi_reset,
    output logic                        irq,
    input  logic                        avs_s0_write,
    input  logic                        avs_s0_read,
    input  logic [$clog2(NUM_CH)+1:0]   avs_s0_address,
    input  logic [31:0]                 avs_s0_writedata,
    output logic [31:0]                 avs_s0_readdata
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned SEL_W = (CH_W > 0) ? CH_W : 1;

    logic [SEL_W-1:0]  ch_sel;
    logic [1:0]        reg_sel;
    logic [31:0]       ctrl_rd  [NUM_CH];
    logic [31:0]       load_rd  [NUM_CH];
    logic [31:0]       count_rd [NUM_CH];
    logic [NUM_CH-1:0] flag_vec;
    logic [NUM_CH-1:0] irq_vec;
    logic [31:0]       rd_mux;
    logic [31:0]       rdata_q;
    logic              irq_q;

    assign reg_sel = avs_s0_address[1:0];

    // A single-channel build has no channel-select bits
    if (CH_W > 0) begin : g_sel
        assign ch_sel = avs_s0_address[CH_W+1:2];
    end else begin : g_sel_none
        assign ch_sel = '0;
    end

    // Channels; an index with no matching instance decodes to nothing
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = avs_s0_write && (ch_sel == SEL_W'(i));

        timer_channel #(
            .CNT_W (CNT_W),
            .PRE_W (PRE_W)
        ) u_channel (
            .clk_i       (csi_clk),
            .rst_i       (rsi_reset),
            .wr_ctrl_i   (hit && (reg_sel == REG_CTRL)),
            .wr_load_i   (hit && (reg_sel == REG_LOAD)),
            .wr_count_i  (hit && (reg_sel == REG_COUNT)),
            .wr_status_i (hit && (reg_sel == REG_STATUS)),
            .wdata_i     (avs_s0_writedata),
            .ctrl_o      (ctrl_rd[i]),
            .load_o      (load_rd[i]),
            .count_o     (count_rd[i]),
            .flag_o      (flag_vec[i]),
            .irq_req_o   (irq_vec[i])
        );
    end

    // Read mux; out-of-range channels fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                case (reg_sel)
                    REG_CTRL:   rd_mux = ctrl_rd[i];
                    REG_LOAD:   rd_mux = load_rd[i];
                    REG_COUNT:  rd_mux = count_rd[i];
                    REG_STATUS: rd_mux = {31'b0, flag_vec[i]};
                    default:    rd_mux = '0;
                endcase
            end
        end
    end

    // Registered readdata (zero when idle) and registered interrupt
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            rdata_q <= avs_s0_read ? rd_mux : '0;
            irq_q   <= |irq_vec;
        end
    end

    assign avs_s0_readdata = rdata_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Scoreboard bench for multi_channel_timer: reads push expectations, a negedge monitor checks.
module tb_multi_channel_timer;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        sel_w = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [31:0] rdata_w;
    logic        irq;
    logic        irq_w;
    logic        rd_vld = 1'b0;
    logic        rd_w_q = 1'b0;

    int          compared = 0;
    int          mismatched = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;

    always #5 clk = ~clk;

    // Main instance: 3 channels so that channel index 3 is out of range
    multi_channel_timer #(
        .NUM_CH (3),
        .CNT_W  (24),
        .PRE_W  (8)
    ) u_dut (
        .csi_clk          (clk),
        .rsi_reset        (rst),
        .irq              (irq),
        .avs_s0_write     (wr & ~sel_w),
        .avs_s0_read      (rd & ~sel_w),
        .avs_s0_address   (addr),
        .avs_s0_writedata (wdata),
        .avs_s0_readdata  (rdata)
    );

    // Narrow instance: 4-bit counter so the LOAD-below-count wrap is reachable
    multi_channel_timer #(
        .NUM_CH (1),
        .CNT_W  (4),
        .PRE_W  (2)
    ) u_dut_w (
        .csi_clk          (clk),
        .rsi_reset        (rst),
        .irq              (irq_w),
        .avs_s0_write     (wr & sel_w),
        .avs_s0_read      (rd & sel_w),
        .avs_s0_address   (addr[1:0]),
        .avs_s0_writedata (wdata),
        .avs_s0_readdata  (rdata_w)
    );

    // Remember which instance was read so the monitor knows where data appears
    always @(posedge clk) begin
        rd_vld <= rd;
        rd_w_q <= sel_w;
    end

    // Monitor: one cycle after each read strobe, pop and compare
    always @(negedge clk) begin
        if (rd_vld) begin
            mon_act = rd_w_q ? rdata_w : rdata;
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_read: got 0x%08h with no expectation queued", mon_act);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_act !== mon_e.exp) begin
                    mismatched++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, mon_act,
                             mon_e.exp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        cyc(1);
        wr    = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [31:0] e, input string n);
        addr = a;
        rd   = 1'b1;
        sb_q.push_back('{n, e});
        cyc(1);
        rd   = 1'b0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        compared++;
        if (act !== e) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        cyc(2);
        rst = 1'b0;
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rd_reg(4'h0, 32'h0, "rst_ctrl0");
        rd_reg(4'h1, 32'h0, "rst_load0");
        rd_reg(4'h2, 32'h0, "rst_count0");
        rd_reg(4'h3, 32'h0, "rst_status0");

        // Periodic, PRESCALE=0, LOAD=3 on ch0: expiry 4 cycles after the enable write
        wr_reg(4'h1, 32'd3);
        wr_reg(4'h0, 32'h7);
        rd_reg(4'h3, 32'h0, "p_flag_c1");
        rd_reg(4'h2, 32'd1, "p_count_c2");
        rd_reg(4'h2, 32'd2, "p_count_c3");
        rd_reg(4'h3, 32'h0, "p_flag_c4");
        chk("p_irq_before", {31'b0, irq}, 32'h0);
        rd_reg(4'h3, 32'h1, "p_flag_c5");
        chk("p_irq_after", {31'b0, irq}, 32'h1);
        wr_reg(4'h3, 32'h1);
        chk("p_irq_w1c_lag", {31'b0, irq}, 32'h1);
        cyc(1);
        chk("p_irq_cleared", {31'b0, irq}, 32'h0);
        rd_reg(4'h3, 32'h0, "p_flag_c8");
        rd_reg(4'h3, 32'h1, "p_flag_c9");

        // W1C landing in the exact expiry cycle: set wins
        cyc(2);
        wr_reg(4'h3, 32'h1);
        chk("col_irq_a", {31'b0, irq}, 32'h1);
        rd_reg(4'h3, 32'h1, "col_flag");
        chk("col_irq_b", {31'b0, irq}, 32'h1);

        // Disable freezes count (one last tick lands in the write cycle)
        wr_reg(4'h0, 32'h0);
        wr_reg(4'h3, 32'h1);
        rd_reg(4'h2, 32'd2, "frz_count_a");
        cyc(3);
        rd_reg(4'h2, 32'd2, "frz_count_b");

        // One-shot on ch1: LOAD=5, PRESCALE=2 -> single expiry 18 cycles after enable
        wr_reg(4'h5, 32'd5);
        wr_reg(4'h4, 32'h205);
        cyc(17);
        rd_reg(4'h7, 32'h0, "os_flag_c18");
        rd_reg(4'h7, 32'h1, "os_flag_c19");
        chk("os_irq", {31'b0, irq}, 32'h1);
        rd_reg(4'h6, 32'd5, "os_count_hold");
        rd_reg(4'h4, 32'h204, "os_ctrl_disarmed");
        wr_reg(4'h7, 32'h1);
        cyc(100);
        chk("os_irq_quiet", {31'b0, irq}, 32'h0);
        rd_reg(4'h7, 32'h0, "os_flag_quiet");
        rd_reg(4'h6, 32'd5, "os_count_quiet");

        // Multi-channel: ch0 LOAD=9 no IRQ_EN, ch2 LOAD=4 with IRQ_EN
        wr_reg(4'h1, 32'd9);
        wr_reg(4'h9, 32'd4);
        wr_reg(4'h0, 32'h3);
        wr_reg(4'h8, 32'h7);
        cyc(5);
        chk("mc_irq_c6", {31'b0, irq}, 32'h0);
        cyc(1);
        chk("mc_irq_c7", {31'b0, irq}, 32'h1);
        cyc(2);
        rd_reg(4'h3, 32'h0, "mc_ch0_flag_c10");
        rd_reg(4'h3, 32'h1, "mc_ch0_flag_c11");
        chk("mc_irq_c11", {31'b0, irq}, 32'h1);
        wr_reg(4'hB, 32'h1);
        cyc(1);
        chk("mc_irq_ch0_masked", {31'b0, irq}, 32'h0);
        rd_reg(4'hC, 32'h0, "oor_ctrl");
        rd_reg(4'hF, 32'h0, "oor_status");
        rd_reg(4'hE, 32'h0, "oor_count");
        wr_reg(4'h0, 32'h0);
        wr_reg(4'h8, 32'h0);
        wr_reg(4'h3, 32'h1);
        wr_reg(4'hB, 32'h1);
        cyc(1);
        chk("mc_irq_idle", {31'b0, irq}, 32'h0);

        // Reset pulse while ch0 count is 2
        wr_reg(4'h0, 32'h7);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mr_irq", {31'b0, irq}, 32'h0);
        chk("mr_rdata", rdata, 32'h0);
        rd_reg(4'h0, 32'h0, "mr_ctrl0");
        rd_reg(4'h1, 32'h0, "mr_load0");
        rd_reg(4'h2, 32'h0, "mr_count0");
        rd_reg(4'h3, 32'h0, "mr_status0");
        rd_reg(4'h9, 32'h0, "mr_load2");
        rd_reg(4'h4, 32'h0, "mr_ctrl1");
        cyc(20);
        rd_reg(4'h3, 32'h0, "mr_status0_late");
        rd_reg(4'h2, 32'h0, "mr_count0_late");
        chk("mr_irq_late", {31'b0, irq}, 32'h0);

        // LOAD readback is truncated to CNT_W; readdata drops to 0 after the read
        wr_reg(4'h5, 32'hFFFF_FFFF);
        rd_reg(4'h5, 32'h00FF_FFFF, "rb_load_trunc");
        cyc(1);
        chk("rb_rdata_idle", rdata, 32'h0);

        // Narrow instance: LOAD lowered below count -> runs through 15 -> 0 before matching
        sel_w = 1'b1;
        wr_reg(4'h1, 32'd10);
        wr_reg(4'h0, 32'h3);
        cyc(5);
        wr_reg(4'h1, 32'd3);
        cyc(5);
        rd_reg(4'h3, 32'h0, "wr_flag_c12");
        rd_reg(4'h2, 32'd12, "wr_count_c13");
        cyc(6);
        rd_reg(4'h3, 32'h0, "wr_flag_c20");
        rd_reg(4'h3, 32'h1, "wr_flag_c21");
        rd_reg(4'h2, 32'd1, "wr_count_c22");
        sel_w = 1'b0;
        chk("wr_irq_masked", {31'b0, irq_w}, 32'h0);

        cyc(3);
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_drain: got %0d leftover expectations expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
